// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared widths, stall bit indices and FSM encoding for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int INST_ADDR_W = 32;
  localparam int STALL_W     = 6;

  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;
  localparam int STALL_RSVD   = 5;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Each pattern freezes the stages up to and including the one waiting.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_LU   = 6'b000111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LU      = 2'd1,
    ST_EX_WAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_ctrl_ld_use_detect.sv
// rtl/pipe_ctrl_ld_use_detect.sv - load-use hazard between decode reads and the load in EX
module ld_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  reg1_read,
  input  logic [REG_ADDR_W-1:0] reg1_addr,
  input  logic                  reg2_read,
  input  logic [REG_ADDR_W-1:0] reg2_addr,
  input  logic                  ex_wreg,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_is_load,
  output logic                  hazard
);

  logic load_writes;
  logic rs_hit;
  logic rt_hit;

  // $0 is hardwired, so a load targeting it never produces data worth waiting for.
  assign load_writes = ex_is_load & ex_wreg & (ex_wd != '0);
  assign rs_hit      = reg1_read & (reg1_addr == ex_wd);
  assign rt_hit      = reg2_read & (reg2_addr == ex_wd);
  assign hazard      = load_writes & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall/flush sequencer with stall-cycle counter
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_reg1_read_i,
  input  logic [REG_ADDR_W-1:0]  id_reg1_addr_i,
  input  logic                   id_reg2_read_i,
  input  logic [REG_ADDR_W-1:0]  id_reg2_addr_i,
  input  logic                   ex_wreg_i,
  input  logic [REG_ADDR_W-1:0]  ex_wd_i,
  input  logic                   ex_is_load_i,
  input  logic                   ex_busy_req_i,
  input  logic                   ex_done_i,
  input  logic                   mem_stallreq_i,
  input  logic                   flush_req_i,
  input  logic [INST_ADDR_W-1:0] flush_pc_i,
  output logic [STALL_W-1:0]     stall_o,
  output logic                   flush_o,
  output logic [INST_ADDR_W-1:0] new_pc_o,
  output logic [PERF_W-1:0]      stall_cnt_o
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t             state;
  logic [3:0]         flush_cnt;
  logic               hazard;
  logic [STALL_W-1:0] stall_raw;

  ld_use_detect u_ld_use_detect (
    .reg1_read  (id_reg1_read_i),
    .reg1_addr  (id_reg1_addr_i),
    .reg2_read  (id_reg2_read_i),
    .reg2_addr  (id_reg2_addr_i),
    .ex_wreg    (ex_wreg_i),
    .ex_wd      (ex_wd_i),
    .ex_is_load (ex_is_load_i),
    .hazard     (hazard)
  );

  always_comb begin
    stall_raw = STALL_NONE;
    if (state == ST_FLUSH || flush_req_i) begin
      stall_raw = STALL_NONE;
    end else if (mem_stallreq_i) begin
      stall_raw = STALL_MEM;
    end else if ((state == ST_EX_WAIT && !ex_done_i) || ex_busy_req_i) begin
      stall_raw = STALL_EX;
    end else if (hazard && state == ST_RUN) begin
      stall_raw = STALL_LU;
    end
  end

  // Stall must act in the same cycle, so it is combinational but held off during reset.
  assign stall_o = rst ? stall_raw : STALL_NONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      flush_cnt   <= '0;
      flush_o     <= DISABLE;
      new_pc_o    <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (stall_o[STALL_PC] && stall_cnt_o != '1) begin
        stall_cnt_o <= stall_cnt_o + PERF_W'(1);
      end
      if (flush_req_i) begin
        state     <= ST_FLUSH;
        flush_cnt <= FLUSH_LOAD;
        flush_o   <= ENABLE;
        new_pc_o  <= flush_pc_i;
      end else begin
        case (state)
          ST_RUN: begin
            if (ex_busy_req_i) begin
              state <= ST_EX_WAIT;
            end else if (hazard && !mem_stallreq_i) begin
              state <= ST_LU;
            end
          end
          ST_LU: begin
            state <= ex_busy_req_i ? ST_EX_WAIT : ST_RUN;
          end
          ST_EX_WAIT: begin
            if (ex_done_i) begin
              state <= ST_RUN;
            end
          end
          ST_FLUSH: begin
            if (flush_cnt <= 4'd1) begin
              state     <= ST_RUN;
              flush_cnt <= '0;
              flush_o   <= DISABLE;
            end else begin
              flush_cnt <= flush_cnt - 4'd1;
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with directed vectors
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_reg1_read_i;
  logic [4:0]  id_reg1_addr_i;
  logic        id_reg2_read_i;
  logic [4:0]  id_reg2_addr_i;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic        ex_is_load_i;
  logic        ex_busy_req_i;
  logic        ex_done_i;
  logic        mem_stallreq_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] stall_cnt_o;

  pipe_ctrl #(.FLUSH_CYCLES(2), .PERF_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_busy_req_i  (ex_busy_req_i),
    .ex_done_i      (ex_done_i),
    .mem_stallreq_i (mem_stallreq_i),
    .flush_req_i    (flush_req_i),
    .flush_pc_i     (flush_pc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = '0;
  logic [31:0] exp_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("stall_o", 32'(stall_o), 32'(e.stall));
      chk("flush_o", 32'(flush_o), 32'(e.flush));
      chk("new_pc_o", new_pc_o, e.pc);
      chk("stall_cnt_o", stall_cnt_o, e.cnt);
    end
  end

  task automatic idle();
    id_reg1_read_i = 0; id_reg1_addr_i = '0;
    id_reg2_read_i = 0; id_reg2_addr_i = '0;
    ex_wreg_i = 0; ex_wd_i = '0; ex_is_load_i = 0;
    ex_busy_req_i = 0; ex_done_i = 0; mem_stallreq_i = 0;
    flush_req_i = 0; flush_pc_i = '0;
  endtask

  task automatic load(input logic [4:0] wd, input logic r1, input logic [4:0] a1,
                      input logic r2, input logic [4:0] a2);
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = wd;
    id_reg1_read_i = r1; id_reg1_addr_i = a1;
    id_reg2_read_i = r2; id_reg2_addr_i = a2;
  endtask

  // Inputs for this cycle are already driven; queue what the DUT must show, then advance.
  task automatic step(input logic [5:0] s, input logic f);
    sb.push_back({s, f, exp_pc, exp_cnt});
    if (s[0]) exp_cnt = exp_cnt + 1;
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    rst = 0;
    idle();
    @(posedge clk); #1;
    load(5'd5, 1, 5'd5, 0, 5'd0); mem_stallreq_i = 1; ex_busy_req_i = 1;
    step(6'b000000, 0);
    rst = 1;
    step(6'b000000, 0);

    // load-use on rs: one bubble, hazard repeated in LU is ignored
    load(5'd5, 1, 5'd5, 0, 5'd0); step(6'b000111, 0);
    load(5'd5, 1, 5'd5, 0, 5'd0); step(6'b000000, 0);
    step(6'b000000, 0);
    // load-use on rt
    load(5'd7, 0, 5'd0, 1, 5'd7); step(6'b000111, 0);
    step(6'b000000, 0);
    // $0 target never stalls, state stays RUN
    load(5'd0, 1, 5'd0, 1, 5'd0); step(6'b000000, 0);
    load(5'd0, 1, 5'd0, 1, 5'd0); step(6'b000000, 0);
    load(5'd9, 1, 5'd9, 0, 5'd0); step(6'b000111, 0);
    // not a load / read not enabled
    load(5'd3, 1, 5'd3, 0, 5'd0); ex_is_load_i = 0; step(6'b000000, 0);
    load(5'd3, 0, 5'd3, 0, 5'd3); step(6'b000000, 0);

    // multi-cycle: 35 stalled cycles, busy beats a simultaneous hazard
    load(5'd4, 1, 5'd4, 0, 5'd0); ex_busy_req_i = 1; step(6'b001111, 0);
    for (int i = 0; i < 34; i++) step(6'b001111, 0);
    ex_done_i = 1; step(6'b000000, 0);
    load(5'd6, 0, 5'd0, 1, 5'd6); step(6'b000111, 0);
    step(6'b000000, 0);

    // memory overlay with done accepted during the memory stall
    ex_busy_req_i = 1; step(6'b001111, 0);
    step(6'b001111, 0);
    mem_stallreq_i = 1; step(6'b011111, 0);
    mem_stallreq_i = 1; ex_done_i = 1; step(6'b011111, 0);
    mem_stallreq_i = 1; step(6'b011111, 0);
    step(6'b000000, 0);

    // flush aborts EX_WAIT, overrides memory stall, late done ignored
    ex_busy_req_i = 1; step(6'b001111, 0);
    step(6'b001111, 0);
    flush_req_i = 1; flush_pc_i = 32'h0000_0180; mem_stallreq_i = 1; step(6'b000000, 0);
    exp_pc = 32'h0000_0180;
    mem_stallreq_i = 1; step(6'b000000, 1);
    step(6'b000000, 1);
    ex_done_i = 1; step(6'b000000, 0);
    step(6'b000000, 0);
    load(5'd8, 1, 5'd8, 0, 5'd0); step(6'b000111, 0);
    step(6'b000000, 0);

    // re-flush during FLUSH restarts the count and recaptures the PC
    flush_req_i = 1; flush_pc_i = 32'h0000_0200; step(6'b000000, 0);
    exp_pc = 32'h0000_0200;
    flush_req_i = 1; flush_pc_i = 32'h0000_0300; step(6'b000000, 1);
    exp_pc = 32'h0000_0300;
    step(6'b000000, 1);
    step(6'b000000, 1);
    step(6'b000000, 0);

    // flush and done together: flush wins
    ex_busy_req_i = 1; step(6'b001111, 0);
    flush_req_i = 1; ex_done_i = 1; flush_pc_i = 32'h0000_0040; step(6'b000000, 0);
    exp_pc = 32'h0000_0040;
    step(6'b000000, 1);
    step(6'b000000, 1);
    load(5'd2, 1, 5'd2, 0, 5'd0); step(6'b000111, 0);
    step(6'b000000, 0);

    // asynchronous reset in EX_WAIT with busy still requested
    ex_busy_req_i = 1; step(6'b001111, 0);
    step(6'b001111, 0);
    ex_busy_req_i = 1; rst = 0; exp_cnt = '0; exp_pc = '0;
    step(6'b000000, 0);
    rst = 0; ex_busy_req_i = 1; step(6'b000000, 0);
    rst = 1;
    step(6'b000000, 0);
    load(5'd5, 1, 5'd5, 0, 5'd0); step(6'b000111, 0);
    step(6'b000000, 0);

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got no end expected end by %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
